// File: rtl/ysyx_20020207_trap_ctrl.sv
// Trap/mret sequencer: serialises mepc/mcause/mstatus writes onto one CSR port, then redirects fetch.
// Optional external-interrupt entry is enabled by defining YSYX_20020207_TRAP_IRQ_EN.
module ysyx_20020207_trap_ctrl #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] ECALL_CAUSE = 32'h0000_000b,
  parameter logic [XLEN-1:0] ILL_CAUSE   = 32'h0000_0002
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_trap_valid,
  output logic            o_trap_ready,
  input  logic [1:0]      i_trap_kind,
  input  logic [XLEN-1:0] i_trap_pc,
  input  logic            i_csrw_valid,
  output logic            o_csrw_ready,
  input  logic [11:0]     i_csrw_addr,
  input  logic [XLEN-1:0] i_csrw_data,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mepc,
  input  logic [XLEN-1:0] i_mstatus,
`ifdef YSYX_20020207_TRAP_IRQ_EN
  input  logic            i_irq,
  input  logic [XLEN-1:0] i_irq_pc,
`endif
  output logic            o_csr_wen,
  output logic [11:0]     o_csr_waddr,
  output logic [XLEN-1:0] o_csr_wdata,
  output logic            o_redir_valid,
  input  logic            i_redir_ready,
  output logic [XLEN-1:0] o_redir_pc,
  output logic            o_busy,
  output logic            o_halt
);

  typedef enum logic [2:0] {
    S_IDLE, S_EPC, S_CAUSE, S_STATUS, S_REDIR, S_HALT
  } state_t;

  localparam logic [XLEN-1:0] IRQ_CAUSE = {1'b1, (XLEN-1)'(11)};

  state_t          r_state;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_redir_pc;
  logic            r_is_mret;
  logic            r_halt;

  logic            w_irq_take;
  logic [XLEN-1:0] w_irq_pc;
  logic            w_trap_acc;
  logic [XLEN-1:0] w_status_trap;
  logic [XLEN-1:0] w_status_mret;

`ifdef YSYX_20020207_TRAP_IRQ_EN
  assign w_irq_take = i_irq && i_mstatus[3];
  assign w_irq_pc   = i_irq_pc;
`else
  assign w_irq_take = 1'b0;
  assign w_irq_pc   = '0;
`endif

  // Trap beats interrupt beats CSR-instruction write when they collide in IDLE.
  assign o_trap_ready  = (r_state == S_IDLE);
  assign o_csrw_ready  = (r_state == S_IDLE) && !i_trap_valid && !w_irq_take;
  assign w_trap_acc    = i_trap_valid && o_trap_ready;
  assign o_redir_valid = (r_state == S_REDIR);
  assign o_redir_pc    = r_redir_pc;
  assign o_busy        = (r_state != S_IDLE);
  assign o_halt        = r_halt;

  always_comb begin
    w_status_trap        = i_mstatus;
    w_status_trap[7]     = i_mstatus[3];
    w_status_trap[3]     = 1'b0;
    w_status_trap[12:11] = 2'b11;
    w_status_mret        = i_mstatus;
    w_status_mret[3]     = i_mstatus[7];
    w_status_mret[7]     = 1'b1;
    w_status_mret[12:11] = 2'b11;
  end

  always_comb begin
    o_csr_wen   = 1'b0;
    o_csr_waddr = 12'h000;
    o_csr_wdata = '0;
    case (r_state)
      S_IDLE: begin
        o_csr_wen   = i_csrw_valid && o_csrw_ready;
        o_csr_waddr = i_csrw_addr;
        o_csr_wdata = i_csrw_data;
      end
      S_EPC: begin
        o_csr_wen   = 1'b1;
        o_csr_waddr = 12'h341;
        o_csr_wdata = r_epc;
      end
      S_CAUSE: begin
        o_csr_wen   = 1'b1;
        o_csr_waddr = 12'h342;
        o_csr_wdata = r_cause;
      end
      S_STATUS: begin
        o_csr_wen   = 1'b1;
        o_csr_waddr = 12'h300;
        o_csr_wdata = r_is_mret ? w_status_mret : w_status_trap;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_epc      <= '0;
      r_cause    <= '0;
      r_redir_pc <= '0;
      r_is_mret  <= 1'b0;
      r_halt     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_trap_acc) begin
            case (i_trap_kind)
              2'b00: begin
                r_epc     <= i_trap_pc;
                r_cause   <= ECALL_CAUSE;
                r_is_mret <= 1'b0;
                r_state   <= S_EPC;
              end
              2'b11: begin
                r_epc     <= i_trap_pc;
                r_cause   <= ILL_CAUSE;
                r_is_mret <= 1'b0;
                r_state   <= S_EPC;
              end
              2'b10: begin
                r_is_mret  <= 1'b1;
                r_redir_pc <= i_mepc;
                r_state    <= S_STATUS;
              end
              default: begin
                r_halt  <= 1'b1;
                r_state <= S_HALT;
              end
            endcase
          end else if (w_irq_take) begin
            r_epc     <= w_irq_pc;
            r_cause   <= IRQ_CAUSE;
            r_is_mret <= 1'b0;
            r_state   <= S_EPC;
          end
        end
        S_EPC:   r_state <= S_CAUSE;
        S_CAUSE: r_state <= S_STATUS;
        S_STATUS: begin
          // Trap vector is sampled here so a same-sequence mtvec update is honoured.
          if (!r_is_mret) r_redir_pc <= i_mtvec & ~XLEN'(3);
          r_state <= S_REDIR;
        end
        S_REDIR: if (i_redir_ready) r_state <= S_IDLE;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_20020207_trap_ctrl.sv
// Randomised directed bench for ysyx_20020207_trap_ctrl with a transaction-level reference model.
module tb_ysyx_20020207_trap_ctrl;
  logic        clk;
  logic        rst_n;
  logic        trap_valid;
  logic        trap_ready;
  logic [1:0]  trap_kind;
  logic [31:0] trap_pc;
  logic        csrw_valid;
  logic        csrw_ready;
  logic [11:0] csrw_addr;
  logic [31:0] csrw_data;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mstatus;
  logic        csr_wen;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        redir_valid;
  logic        redir_ready;
  logic [31:0] redir_pc;
  logic        busy;
  logic        halt;
`ifdef YSYX_20020207_TRAP_IRQ_EN
  logic        irq;
  logic [31:0] irq_pc;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [11:0] exp_addr [3];
  logic [31:0] exp_data [3];
  int          exp_n;
  logic [31:0] exp_redir;

  ysyx_20020207_trap_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_trap_valid(trap_valid), .o_trap_ready(trap_ready),
    .i_trap_kind(trap_kind), .i_trap_pc(trap_pc),
    .i_csrw_valid(csrw_valid), .o_csrw_ready(csrw_ready),
    .i_csrw_addr(csrw_addr), .i_csrw_data(csrw_data),
    .i_mtvec(mtvec), .i_mepc(mepc), .i_mstatus(mstatus),
`ifdef YSYX_20020207_TRAP_IRQ_EN
    .i_irq(irq), .i_irq_pc(irq_pc),
`endif
    .o_csr_wen(csr_wen), .o_csr_waddr(csr_waddr), .o_csr_wdata(csr_wdata),
    .o_redir_valid(redir_valid), .i_redir_ready(redir_ready), .o_redir_pc(redir_pc),
    .o_busy(busy), .o_halt(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected CSR write list and redirect target for one accepted event.
  // kind 0/3 = ecall/illegal, 2 = mret; irq selects the interrupt entry.
  task automatic model(input logic [1:0] kind, input bit is_irq, input logic [31:0] pc,
                       input logic [31:0] tv, input logic [31:0] ms, input logic [31:0] ep);
    logic [31:0] st;
    if (kind == 2'b10 && !is_irq) begin
      st = (ms & ~32'h0000_1888) | 32'h0000_1880 | (ms[7] ? 32'h8 : 32'h0);
      exp_n = 1;
      exp_addr[0] = 12'h300; exp_data[0] = st;
      exp_redir = ep;
    end else begin
      st = (ms & ~32'h0000_1888) | 32'h0000_1800 | (ms[3] ? 32'h80 : 32'h0);
      exp_n = 3;
      exp_addr[0] = 12'h341; exp_data[0] = pc;
      exp_addr[1] = 12'h342;
      exp_data[1] = is_irq ? 32'h8000_000b : (kind == 2'b00 ? 32'h0000_000b : 32'h0000_0002);
      exp_addr[2] = 12'h300; exp_data[2] = st;
      exp_redir = (tv >> 2) * 4;
    end
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic run_trap(input logic [1:0] kind, input logic [31:0] pc, input logic [31:0] tv,
                          input logic [31:0] ms, input logic [31:0] ep, input int stall,
                          input bit conflict, input bit use_irq);
    model(kind, use_irq, pc, tv, ms, ep);
    mtvec = tv; mstatus = ms; mepc = ep; trap_pc = pc; trap_kind = kind;
    csrw_valid = conflict; csrw_addr = 12'($urandom); csrw_data = $urandom;
    if (use_irq) begin
`ifdef YSYX_20020207_TRAP_IRQ_EN
      irq = 1'b1; irq_pc = pc;
`endif
      trap_valid = 1'b0;
    end else begin
      trap_valid = 1'b1;
    end
    @(negedge clk);
    chk1("accept_trap_ready", trap_ready, 1'b1);
    if (conflict) begin
      chk1("conflict_csrw_ready", csrw_ready, 1'b0);
      chk1("conflict_csr_wen", csr_wen, 1'b0);
    end
    @(posedge clk); #1;
`ifdef YSYX_20020207_TRAP_IRQ_EN
    irq = 1'b0;
`endif
    for (int i = 0; i < exp_n; i++) begin
      trap_valid = 1'($urandom_range(0, 1));
      trap_kind  = 2'($urandom_range(0, 3));
      csrw_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk1("seq_wen", csr_wen, 1'b1);
      chk("seq_waddr", 32'(csr_waddr), 32'(exp_addr[i]));
      chk("seq_wdata", csr_wdata, exp_data[i]);
      chk1("seq_no_redir", redir_valid, 1'b0);
      @(posedge clk); #1;
    end
    for (int s = 0; s <= stall; s++) begin
      redir_ready = (s == stall);
      trap_valid  = 1'($urandom_range(0, 1));
      csrw_valid  = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk1("redir_valid", redir_valid, 1'b1);
      chk("redir_pc", redir_pc, exp_redir);
      chk1("redir_wen", csr_wen, 1'b0);
      @(posedge clk); #1;
    end
    redir_ready = 1'b0; trap_valid = 1'b0; csrw_valid = 1'b0;
    @(negedge clk);
    chk1("post_redir_valid", redir_valid, 1'b0);
    chk1("post_busy", busy, 1'b0);
    chk1("post_trap_ready", trap_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic csr_direct(input logic [11:0] a, input logic [31:0] d);
    trap_valid = 1'b0; csrw_valid = 1'b1; csrw_addr = a; csrw_data = d;
    @(negedge clk);
    chk1("direct_ready", csrw_ready, 1'b1);
    chk1("direct_wen", csr_wen, 1'b1);
    chk("direct_waddr", 32'(csr_waddr), 32'(a));
    chk("direct_wdata", csr_wdata, d);
    @(posedge clk); #1;
    csrw_valid = 1'b0;
    @(negedge clk);
    chk1("direct_idle", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [1:0] kinds [3];
    logic [1:0] k;
    kinds[0] = 2'b00; kinds[1] = 2'b10; kinds[2] = 2'b11;
    rst_n = 1'b1; trap_valid = 1'b0; trap_kind = 2'b00; trap_pc = '0;
    csrw_valid = 1'b0; csrw_addr = '0; csrw_data = '0;
    mtvec = '0; mepc = '0; mstatus = '0; redir_ready = 1'b0;
`ifdef YSYX_20020207_TRAP_IRQ_EN
    irq = 1'b0; irq_pc = '0;
`endif
    #1 rst_n = 1'b0;
    #3;
    chk1("rst_csr_wen", csr_wen, 1'b0);
    chk1("rst_redir_valid", redir_valid, 1'b0);
    chk("rst_redir_pc", redir_pc, 32'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_halt", halt, 1'b0);
    chk1("rst_trap_ready", trap_ready, 1'b1);

    // ebreak accepted on the very first edge after reset release; halt is sticky.
    trap_valid = 1'b1; trap_kind = 2'b01;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("ebreak_halt", halt, 1'b1);
    chk1("ebreak_busy", busy, 1'b1);
    chk1("ebreak_trap_ready", trap_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      trap_valid = 1'($urandom_range(0, 1));
      trap_kind  = 2'($urandom_range(0, 3));
      csrw_valid = 1'b1;
      @(negedge clk);
      chk1("halt_sticky", halt, 1'b1);
      chk1("halt_no_wen", csr_wen, 1'b0);
      chk1("halt_no_redir", redir_valid, 1'b0);
      chk1("halt_csrw_ready", csrw_ready, 1'b0);
      @(posedge clk); #1;
    end
    trap_valid = 1'b0; csrw_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk1("halt_rst_halt", halt, 1'b0);
    chk1("halt_rst_busy", busy, 1'b0);
    chk1("halt_rst_wen", csr_wen, 1'b0);
    chk1("halt_rst_trap_ready", trap_ready, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;

    run_trap(2'b00, 32'h8000_0100, 32'h8000_0003, 32'h0000_0008, 32'h0, 0, 1'b1, 1'b0);
    run_trap(2'b10, 32'h0, 32'h0, 32'h0000_1880, 32'h8000_0104, 1, 1'b0, 1'b0);
    run_trap(2'b11, 32'h8000_0040, 32'h8000_1001, 32'h0000_0000, 32'h0, 5, 1'b0, 1'b0);
    csr_direct(12'h305, 32'h8000_0000);
    csr_direct(12'h340, $urandom);

    // Reset while in CAUSE aborts the sequence for good.
    trap_valid = 1'b1; trap_kind = 2'b00; trap_pc = 32'h8000_0500;
    @(posedge clk); #1 trap_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midcause_waddr", 32'(csr_waddr), 32'h342);
    #2 rst_n = 1'b0;
    #1;
    chk1("midcause_busy", busy, 1'b0);
    chk1("midcause_wen", csr_wen, 1'b0);
    chk1("midcause_redir", redir_valid, 1'b0);
    chk1("midcause_trap_ready", trap_ready, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("no_resume_busy", busy, 1'b0);
      chk1("no_resume_wen", csr_wen, 1'b0);
    end
    @(posedge clk); #1;

    for (int n = 0; n < 24; n++) begin
      k = kinds[$urandom_range(0, 2)];
      run_trap(k, $urandom & ~32'h3, $urandom, $urandom, $urandom,
               $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 2) == 0) csr_direct(12'($urandom), $urandom);
    end

`ifdef YSYX_20020207_TRAP_IRQ_EN
    run_trap(2'b00, 32'h8000_0200, 32'h8000_0000, 32'h0000_0008, 32'h0, 0, 1'b1, 1'b1);
    irq = 1'b1; irq_pc = 32'h8000_0300; mstatus = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("irq_masked_busy", busy, 1'b0);
      chk1("irq_masked_csrw_ready", csrw_ready, 1'b1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk1("irq_masked_still_idle", busy, 1'b0);
    irq = 1'b0;
    @(posedge clk); #1;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ysyx_20020207_trap_ctrl.md
YSYX_20020207_TRAP_CTRL -- requirements
Module: ysyx_20020207_trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/PC width.
REQ-002 SHALL have parameter ECALL_CAUSE, default 32'h0000_000b, meaning mcause value for ecall.
REQ-003 SHALL have parameter ILL_CAUSE, default 32'h0000_0002, meaning mcause value for illegal instruction.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 trap_valid  in  1  trap request from decode.
REQ-007 trap_ready  out  1  trap request accepted when high with trap_valid.
REQ-008 trap_kind  in  2  00 ecall, 01 ebreak, 10 mret, 11 illegal.
REQ-009 trap_pc  in  XLEN  PC of the trapping instruction.
REQ-010 csrw_valid / csrw_ready  in / out  1 / 1  CSR-instruction write request/grant.
REQ-011 csrw_addr  in  12; csrw_data  in  XLEN  CSR-instruction write address/data.
REQ-012 mtvec_i, mepc_i, mstatus_i  in  XLEN each  current CSR values from CSR file.
REQ-013 csr_wen  out  1; csr_waddr  out  12; csr_wdata  out  XLEN  single CSR file write port.
REQ-014 redir_valid  out  1; redir_ready  in  1; redir_pc  out  XLEN  PC redirect to fetch.
REQ-015 busy  out  1 (state != IDLE); halt  out  1 (ebreak seen).
REQ-016 irq_i  in  1; irq_pc  in  XLEN  external interrupt and resume PC (present only under REQ-033).

Function
REQ-017 FSM states SHALL be IDLE, EPC, CAUSE, STATUS, REDIR, HALT.
REQ-018 trap_ready SHALL equal (state==IDLE); csrw_ready SHALL equal (state==IDLE && !trap_valid) -- trap beats CSR write on same cycle.
REQ-019 In IDLE, csr_wen=csrw_valid&&csrw_ready, csr_waddr=csrw_addr, csr_wdata=csrw_data, combinationally, same cycle.
REQ-020 Accept of ecall/illegal: latch trap_pc and cause, go IDLE->EPC->CAUSE->STATUS->REDIR, one cycle per write state.
REQ-021 EPC: csr_wen=1, addr 12'h341, data latched PC; CAUSE: addr 12'h342, data latched cause.
REQ-022 STATUS on trap: addr 12'h300, data = mstatus_i with bit7(MPIE)<=bit3(MIE), bit3<=0, bits12:11(MPP)<=2'b11.
REQ-023 Accept of mret: go IDLE->STATUS->REDIR; STATUS data = mstatus_i with bit3<=bit7, bit7<=1, MPP<=2'b11; redirect target latched mepc_i.
REQ-024 Trap redirect target SHALL be mtvec_i with bits1:0 cleared, sampled on entry to REDIR.
REQ-025 REDIR: redir_valid=1, redir_pc stable; leave to IDLE only on cycle with redir_ready=1; redir_valid deasserted next cycle.
REQ-026 ebreak accept: IDLE->HALT; halt=1 from next cycle, sticky; HALT left only by reset; no CSR writes, no redirect.
REQ-027 Outside IDLE, csr_wen SHALL be 0 in REDIR and HALT; trap/csrw inputs ignored.
REQ-028 Latency ecall accept->redir_valid SHALL be exactly 4 cycles; mret 2 cycles.

Reset
REQ-029 On rst_n low, state SHALL go to IDLE immediately, regardless of current state (including mid-sequence and HALT).
REQ-030 Reset values: csr_wen=0, redir_valid=0, redir_pc=0, busy=0, halt=0, latched PC/cause=0; trap_ready=1.
REQ-031 A sequence aborted by reset SHALL NOT be resumed; partial CSR writes already issued remain.
REQ-032 First accept SHALL be possible on the first posedge after rst_n rises.

Configuration
REQ-033 Macro YSYX_20020207_TRAP_IRQ_EN: when defined, irq_i/irq_pc exist; in IDLE with !trap_valid, irq_i && mstatus_i[3] starts EPC sequence with PC=irq_pc, cause 32'h8000_000b, priority over csrw (csrw_ready=0).
REQ-034 Without the macro, ports irq_i/irq_pc SHALL be absent and no interrupt path exists.

Verification
REQ-035 ecall, trap_pc=0x8000_0100, mtvec_i=0x8000_0003, mstatus_i=0x8 -> writes 341<=0x8000_0100, 342<=0xb, 300<=0x1880, redir_pc=0x8000_0000 at cycle +4.
REQ-036 mret, mepc_i=0x8000_0104, mstatus_i=0x1880 -> write 300<=0x1888, redir_pc=0x8000_0104 at +2.
REQ-037 trap_valid and csrw_valid same cycle in IDLE -> csrw_ready=0, no csrw write, trap sequence starts.
REQ-038 redir_ready held 0 for 5 cycles -> redir_valid/redir_pc stable for 5 cycles, IDLE one cycle after redir_ready=1.
REQ-039 ebreak -> halt=1 sticky, trap_ready=0; rst_n pulse low mid-CAUSE and in HALT -> IDLE, halt=0, csr_wen=0.
REQ-040 With YSYX_20020207_TRAP_IRQ_EN, irq_i=1, mstatus_i=0x8, irq_pc=0x8000_0200 -> 342<=0x8000_000b; mstatus_i=0 -> no action.
